// File: rtl/forwarding_scoreboard.sv
// Forwarding select and load-use stall unit for the pipelined MIPS core.
// Keeps a shadow of in-flight destinations from ID/EX to the last write-back.
module forwarding_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int STAGES = 2,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W = 16,
  localparam int SEL_W = $clog2(STAGES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_id_valid,
  input  logic [ADDR_W-1:0] if_id_rs,
  input  logic [ADDR_W-1:0] if_id_rt,
  input  logic [ADDR_W-1:0] if_id_rd,
  input  logic              if_id_EscreveReg,
  input  logic              if_id_LeMem,
  input  logic              flush,
  output logic [SEL_W-1:0]  ForwardA,
  output logic [SEL_W-1:0]  ForwardB,
  output logic              Stall,
  output logic [CNT_W-1:0]  stall_cycles
);

  logic [STAGES:0] vld_q, vld_d;
  logic [STAGES:0] we_q, we_d;
  logic [STAGES-1:0] ld_q, ld_d;
  logic [STAGES:0][ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] rs_q, rs_d;
  logic [ADDR_W-1:0] rt_q, rt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [STAGES:0] live;
  logic [STAGES:1] hit_a, hit_b;
  logic [STAGES-1:0] hit_s, hit_t;
  logic haz_s, haz_t, issue;

  always_comb begin
    live = '0;
    hit_a = '0;
    hit_b = '0;
    hit_s = '0;
    hit_t = '0;
    for (int p = 0; p <= STAGES; p++) begin
      live[p] = vld_q[p] && we_q[p] && (rd_q[p] != '0);
    end
    for (int k = 1; k <= STAGES; k++) begin
      hit_a[k] = live[k] && (rd_q[k] == rs_q);
      hit_b[k] = live[k] && (rd_q[k] == rt_q);
    end
    for (int p = 0; p < STAGES; p++) begin
      hit_s[p] = live[p] && (rd_q[p] == if_id_rs);
      hit_t[p] = live[p] && (rd_q[p] == if_id_rt);
    end
  end

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    ForwardA = '0;
    ForwardB = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (vld_q[0] && hit_a[k]) ForwardA = SEL_W'(k);
      if (vld_q[0] && hit_b[k]) ForwardB = SEL_W'(k);
    end
  end

  always_comb begin
    haz_s = 1'b0;
    haz_t = 1'b0;
    for (int p = STAGES - 1; p >= 0; p--) begin
      if (hit_s[p]) haz_s = ld_q[p] && (p + 1 < LOAD_STAGE);
      if (hit_t[p]) haz_t = ld_q[p] && (p + 1 < LOAD_STAGE);
    end
    Stall = if_id_valid && (haz_s || haz_t) && !flush;
  end

  always_comb begin
    issue = if_id_valid && !flush && !Stall;
    vld_d = {vld_q[STAGES-1:0], issue};
    we_d = {we_q[STAGES-1:0], if_id_EscreveReg};
    rd_d = {rd_q[STAGES-1:0], if_id_rd};
    ld_d = '0;
    ld_d[0] = if_id_LeMem;
    for (int p = 1; p < STAGES; p++) begin
      ld_d[p] = ld_q[p-1];
    end
    rs_d = issue ? if_id_rs : '0;
    rt_d = issue ? if_id_rt : '0;
    cnt_d = cnt_q;
    if (Stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q <= '0;
      we_q <= '0;
      ld_q <= '0;
      rd_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      we_q <= we_d;
      ld_q <= ld_d;
      rd_q <= rd_d;
      rs_q <= rs_d;
      rt_q <= rt_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Bench for forwarding_scoreboard: default and deep-load/narrow-counter builds
// checked against vector tables, directed sequences and an age-list model.
module tb_forwarding_scoreboard;

  typedef struct packed {
    logic v;
    logic [4:0] rs, rt, rd;
    logic we, ld, fl;
  } in_t;

  typedef struct packed {
    logic v, we, ld;
    logic [4:0] rd, rs, rt;
  } ent_t;

  typedef struct {
    in_t x;
    int fa;
    int fb;
    int st;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst0, rst1;
  in_t in_s[2];
  logic [1:0] fa0, fb0, fa1, fb1;
  logic st0, st1;
  logic [15:0] sc0;
  logic [3:0] sc1;

  forwarding_scoreboard dut0 (
    .clock(clock), .reset(rst0),
    .if_id_valid(in_s[0].v), .if_id_rs(in_s[0].rs),
    .if_id_rt(in_s[0].rt), .if_id_rd(in_s[0].rd),
    .if_id_EscreveReg(in_s[0].we), .if_id_LeMem(in_s[0].ld),
    .flush(in_s[0].fl), .ForwardA(fa0), .ForwardB(fb0),
    .Stall(st0), .stall_cycles(sc0)
  );

  forwarding_scoreboard #(.STAGES(3), .LOAD_STAGE(3), .CNT_W(4)) dut1 (
    .clock(clock), .reset(rst1),
    .if_id_valid(in_s[1].v), .if_id_rs(in_s[1].rs),
    .if_id_rt(in_s[1].rt), .if_id_rd(in_s[1].rd),
    .if_id_EscreveReg(in_s[1].we), .if_id_LeMem(in_s[1].ld),
    .flush(in_s[1].fl), .ForwardA(fa1), .ForwardB(fb1),
    .Stall(st1), .stall_cycles(sc1)
  );

  // Model: per build, a list of in-flight instructions indexed by age
  ent_t m[2][4];
  int cnt[2];
  int last_st[2];
  int stg[2] = '{2, 3};
  int lsg[2] = '{2, 3};
  int cmax[2] = '{65535, 15};
  int errors = 0;
  int checks = 0;
  in_t idle = '0;
  vec_t vt[$];

  function automatic in_t mk(logic v, int rs, int rt, int rd,
                             logic we, logic ld, logic fl);
    in_t x;
    x.v = v; x.rs = 5'(rs); x.rt = 5'(rt); x.rd = 5'(rd);
    x.we = we; x.ld = ld; x.fl = fl;
    return x;
  endfunction

  function automatic in_t rnd();
    in_t x;
    x.v = ($urandom % 8) != 0;
    x.rs = 5'($urandom_range(0, 7));
    x.rt = 5'($urandom_range(0, 7));
    x.rd = 5'($urandom_range(0, 7));
    x.we = ($urandom % 4) != 0;
    x.ld = ($urandom % 3) == 0;
    x.fl = ($urandom % 10) == 0;
    return x;
  endfunction

  function automatic logic writes(ent_t e, logic [4:0] s);
    return e.v && e.we && (e.rd != 5'd0) && (e.rd == s);
  endfunction

  function automatic int fwd(int d, logic [4:0] s);
    if (!m[d][0].v) return 0;
    for (int k = 1; k <= stg[d]; k++)
      if (writes(m[d][k], s)) return k;
    return 0;
  endfunction

  function automatic int haz(int d, logic [4:0] s);
    for (int k = 0; k < stg[d]; k++)
      if (writes(m[d][k], s))
        return (m[d][k].ld && (k + 1 < lsg[d])) ? 1 : 0;
    return 0;
  endfunction

  function automatic int mstall(int d);
    in_t x = in_s[d];
    if (x.v && !x.fl && (haz(d, x.rs) != 0 || haz(d, x.rt) != 0))
      return 1;
    return 0;
  endfunction

  function automatic int o_fa(int d);
    return (d == 0) ? int'(fa0) : int'(fa1);
  endfunction
  function automatic int o_fb(int d);
    return (d == 0) ? int'(fb0) : int'(fb1);
  endfunction
  function automatic int o_st(int d);
    return (d == 0) ? int'(st0) : int'(st1);
  endfunction
  function automatic int o_sc(int d);
    return (d == 0) ? int'(sc0) : int'(sc1);
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_model(int d);
    for (int k = 0; k < 4; k++) m[d][k] = '0;
    cnt[d] = 0;
    last_st[d] = 0;
  endtask

  // Compare both builds against the model, then advance one clock.
  task automatic step();
    #2;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d ForwardA", d), o_fa(d), fwd(d, m[d][0].rs));
      chk($sformatf("d%0d ForwardB", d), o_fb(d), fwd(d, m[d][0].rt));
      chk($sformatf("d%0d Stall", d), o_st(d), mstall(d));
      chk($sformatf("d%0d stall_cycles", d), o_sc(d), cnt[d]);
      last_st[d] = mstall(d);
    end
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      if ((d == 0) ? !rst0 : !rst1) begin
        clear_model(d);
      end else begin
        if (last_st[d] != 0 && cnt[d] < cmax[d]) cnt[d]++;
        for (int k = 3; k > 0; k--) m[d][k] = m[d][k-1];
        m[d][0].v = in_s[d].v && !in_s[d].fl && (last_st[d] == 0);
        m[d][0].we = in_s[d].we;
        m[d][0].ld = in_s[d].ld;
        m[d][0].rd = in_s[d].rd;
        m[d][0].rs = in_s[d].rs;
        m[d][0].rt = in_s[d].rt;
      end
    end
    @(negedge clock);
  endtask

  // Drive one build with hand-computed expectations (-1 = model only).
  task automatic hv(int d, in_t x, int efa, int efb, int est);
    in_s[d] = x;
    in_s[1-d] = idle;
    #1;
    if (efa >= 0) chk($sformatf("d%0d hand ForwardA", d), o_fa(d), efa);
    if (efb >= 0) chk($sformatf("d%0d hand ForwardB", d), o_fb(d), efb);
    if (est >= 0) chk($sformatf("d%0d hand Stall", d), o_st(d), est);
    step();
  endtask

  initial begin
    // ALU chain, priority, r0, load-use, flush: default build
    vt.push_back('{mk(1, 0, 0, 1, 1, 0, 0), 0, 0, 0});
    vt.push_back('{mk(1, 1, 2, 6, 1, 0, 0), 0, 0, 0});
    vt.push_back('{mk(1, 7, 8, 9, 1, 0, 0), 1, 0, 0});
    vt.push_back('{mk(1, 6, 0, 10, 1, 0, 0), 0, 0, 0});
    vt.push_back('{mk(1, 0, 0, 4, 1, 0, 0), 2, 0, 0});
    vt.push_back('{mk(1, 0, 0, 4, 1, 0, 0), 0, 0, 0});
    vt.push_back('{mk(1, 0, 4, 11, 1, 0, 0), 0, 0, 0});
    vt.push_back('{mk(1, 0, 0, 0, 1, 0, 0), 0, 1, 0});
    vt.push_back('{mk(1, 0, 0, 12, 1, 0, 0), 0, 0, 0});
    vt.push_back('{mk(0, 0, 0, 0, 0, 0, 0), 0, 0, 0});
    vt.push_back('{mk(1, 0, 0, 3, 1, 1, 0), 0, 0, 0});
    vt.push_back('{mk(1, 3, 0, 13, 1, 0, 0), 0, 0, 1});
    vt.push_back('{mk(1, 3, 0, 13, 1, 0, 0), 0, 0, 0});
    vt.push_back('{mk(0, 0, 0, 0, 0, 0, 0), 2, 0, 0});
    vt.push_back('{mk(1, 0, 0, 0, 1, 1, 0), 0, 0, 0});
    vt.push_back('{mk(1, 0, 0, 14, 1, 0, 0), 0, 0, 0});
    vt.push_back('{mk(1, 0, 0, 5, 1, 1, 0), 0, 0, 0});
    vt.push_back('{mk(1, 0, 5, 15, 1, 0, 1), 0, 0, 0});
    vt.push_back('{mk(0, 0, 0, 0, 0, 0, 0), 0, 0, 0});

    clear_model(0);
    clear_model(1);
    rst0 = 1'b0;
    rst1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_s[0] = rnd();
      in_s[1] = rnd();
      @(posedge clock);
    end
    @(negedge clock);
    rst0 = 1'b1;
    rst1 = 1'b1;
    in_s[0] = idle;
    in_s[1] = idle;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d reset ForwardA", d), o_fa(d), 0);
      chk($sformatf("d%0d reset ForwardB", d), o_fb(d), 0);
      chk($sformatf("d%0d reset Stall", d), o_st(d), 0);
      chk($sformatf("d%0d reset stall_cycles", d), o_sc(d), 0);
    end
    step();

    foreach (vt[i]) hv(0, vt[i].x, vt[i].fa, vt[i].fb, vt[i].st);
    #1 chk("d0 load-use stall_cycles", o_sc(0), 1);

    // Deep load: two stall cycles, then select 3
    hv(1, mk(1, 0, 0, 5, 1, 1, 0), 0, 0, 0);
    hv(1, mk(1, 0, 5, 15, 1, 0, 0), 0, 0, 1);
    hv(1, mk(1, 0, 5, 15, 1, 0, 0), 0, 0, 1);
    hv(1, mk(1, 0, 5, 15, 1, 0, 0), 0, 0, 0);
    hv(1, idle, 0, 3, 0);
    #1 chk("d1 deep-load stall_cycles", o_sc(1), 2);

    // Flush during the first stall cycle
    hv(1, mk(1, 0, 0, 6, 1, 1, 0), 0, 0, 0);
    hv(1, mk(1, 6, 0, 16, 1, 0, 1), 0, 0, 0);
    hv(1, idle, 0, 0, 0);
    #1 chk("d1 flush stall_cycles", o_sc(1), 2);

    // Younger ALU write masks an older load
    hv(1, mk(1, 0, 0, 7, 1, 1, 0), 0, 0, 0);
    hv(1, mk(1, 0, 0, 7, 1, 0, 0), 0, 0, 0);
    hv(1, mk(1, 7, 0, 17, 1, 0, 0), 0, 0, 0);
    hv(1, idle, 1, 0, 0);

    // Reset in the middle of a stall
    hv(1, mk(1, 0, 0, 8, 1, 1, 0), 0, 0, 0);
    rst1 = 1'b0;
    hv(1, mk(1, 8, 0, 18, 1, 0, 0), 0, 0, 1);
    rst1 = 1'b1;
    #1 chk("d1 reset mid-stall stall_cycles", o_sc(1), 0);
    hv(1, mk(1, 8, 0, 18, 1, 0, 0), 0, 0, 0);
    hv(1, idle, 0, 0, 0);

    // Saturation: ten loads, two stall cycles each
    for (int r = 0; r < 10; r++) begin
      hv(1, mk(1, 0, 0, 9, 1, 1, 0), -1, -1, 0);
      hv(1, mk(1, 9, 0, 19, 1, 0, 0), -1, -1, 1);
      hv(1, mk(1, 9, 0, 19, 1, 0, 0), -1, -1, 1);
      hv(1, mk(1, 9, 0, 19, 1, 0, 0), -1, -1, 0);
    end
    #1 chk("d1 saturated stall_cycles", o_sc(1), 15);

    // Random traffic; a stalled instruction is held in IF/ID
    last_st[0] = 0;
    last_st[1] = 0;
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        if (last_st[d] == 0) in_s[d] = rnd();
        else in_s[d].fl = ($urandom % 10) == 0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
